// File: rtl/uart_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : uart_host_sequencer
// Brief   : Sends one opcode+payload command through a uart_tx, then gathers
//           the response bytes (and optional ready char) from a uart_rx.
// Revision: 1.0 - initial release
// ============================================================================
module uart_host_sequencer #(
    parameter int          PAYLOAD_BYTES  = 4,
    parameter int          MAX_RSP_BYTES  = 32,
    parameter int          TIMEOUT_CYCLES = 2_000_000,
    parameter logic [7:0]  READY_CHAR     = 8'h52,
    parameter int          LEN_W          = $clog2(PAYLOAD_BYTES + 1),
    parameter int          RSP_W          = $clog2(MAX_RSP_BYTES + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [7:0]                 i_cmd_opcode,
    input  logic [8*PAYLOAD_BYTES-1:0] i_cmd_payload,
    input  logic [LEN_W-1:0]           i_cmd_pay_len,
    input  logic [RSP_W-1:0]           i_cmd_rsp_len,
    input  logic                       i_cmd_wait_rdy,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_done,
    input  logic                       i_rx_valid,
    input  logic [7:0]                 i_rx_data,
    output logic                       o_rsp_valid,
    output logic [7:0]                 o_rsp_data,
    output logic                       o_rsp_last,
    output logic                       o_done,
    output logic                       o_timeout,
    output logic                       o_busy
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_OP  = 3'd1,
        S_SEND_PAY = 3'd2,
        S_RECV     = 3'd3,
        S_WAIT_R   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic                       tx_start_q, tx_start_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic [7:0]                 opcode_q, opcode_d;
    logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_d;
    logic [LEN_W-1:0]           pay_len_q, pay_len_d;
    logic [RSP_W-1:0]           rsp_len_q, rsp_len_d;
    logic                       wait_q, wait_d;
    logic [LEN_W-1:0]           pay_idx_q, pay_idx_d;
    logic [RSP_W-1:0]           rsp_cnt_q, rsp_cnt_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [7:0]                 rsp_data_q, rsp_data_d;
    logic                       rsp_last_q, rsp_last_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;

    logic [LEN_W-1:0] w_pay_len_clamp;
    logic [RSP_W-1:0] w_rsp_len_clamp;
    logic [7:0]       w_pay_byte;
    logic             w_finish_tx;
    logic             w_rsp_complete;

    assign w_pay_len_clamp = (i_cmd_pay_len > LEN_W'(PAYLOAD_BYTES)) ? LEN_W'(PAYLOAD_BYTES) : i_cmd_pay_len;
    assign w_rsp_len_clamp = (i_cmd_rsp_len > RSP_W'(MAX_RSP_BYTES)) ? RSP_W'(MAX_RSP_BYTES) : i_cmd_rsp_len;

    always_comb begin
        w_pay_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (pay_idx_q == LEN_W'(i)) begin
                w_pay_byte = payload_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        tx_start_d     = tx_start_q;
        tx_data_d      = tx_data_q;
        opcode_d       = opcode_q;
        payload_d      = payload_q;
        pay_len_d      = pay_len_q;
        rsp_len_d      = rsp_len_q;
        wait_d         = wait_q;
        pay_idx_d      = pay_idx_q;
        rsp_cnt_d      = rsp_cnt_q;
        tmo_d          = tmo_q;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        rsp_last_d     = 1'b0;
        done_d         = 1'b0;
        timeout_d      = 1'b0;
        w_finish_tx    = 1'b0;
        w_rsp_complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (i_cmd_valid) begin
                    opcode_d   = i_cmd_opcode;
                    payload_d  = i_cmd_payload;
                    pay_len_d  = w_pay_len_clamp;
                    rsp_len_d  = w_rsp_len_clamp;
                    wait_d     = i_cmd_wait_rdy;
                    pay_idx_d  = '0;
                    rsp_cnt_d  = '0;
                    // Opcode goes out on the very first SEND_OP cycle.
                    tx_start_d = 1'b1;
                    tx_data_d  = i_cmd_opcode;
                    state_d    = S_SEND_OP;
                end
            end

            S_SEND_OP: begin
                if (tx_start_q && i_tx_done) begin
                    tx_start_d = 1'b0;
                    if (pay_len_q != '0) begin
                        pay_idx_d = '0;
                        state_d   = S_SEND_PAY;
                    end else begin
                        w_finish_tx = 1'b1;
                    end
                end
            end

            S_SEND_PAY: begin
                // A low tx_start here is the mandatory one-cycle gap between bytes.
                if (!tx_start_q) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = w_pay_byte;
                end else if (i_tx_done) begin
                    tx_start_d = 1'b0;
                    if (pay_idx_q + LEN_W'(1) == pay_len_q) begin
                        w_finish_tx = 1'b1;
                    end else begin
                        pay_idx_d = pay_idx_q + LEN_W'(1);
                    end
                end
            end

            S_RECV: begin
                if (i_rx_valid) begin
                    tmo_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = i_rx_data;
                    rsp_cnt_d   = rsp_cnt_q + RSP_W'(1);
                    if (rsp_cnt_q + RSP_W'(1) == rsp_len_q) begin
                        rsp_last_d     = 1'b1;
                        w_rsp_complete = 1'b1;
                    end
                end else if (tmo_q == c_TMO_LAST) begin
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_WAIT_R: begin
                if (i_rx_valid) begin
                    tmo_d = '0;
                    if (i_rx_data == READY_CHAR) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == c_TMO_LAST) begin
                    timeout_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d    = S_IDLE;
                tx_start_d = 1'b0;
            end
        endcase

        // A byte arriving together with the final tx_done counts as response byte 1.
        if (w_finish_tx) begin
            tmo_d     = '0;
            rsp_cnt_d = '0;
            if (rsp_len_q != '0) begin
                state_d = S_RECV;
                if (i_rx_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = i_rx_data;
                    rsp_cnt_d   = RSP_W'(1);
                    if (rsp_len_q == RSP_W'(1)) begin
                        rsp_last_d     = 1'b1;
                        w_rsp_complete = 1'b1;
                    end
                end
            end else begin
                w_rsp_complete = 1'b1;
            end
        end

        if (w_rsp_complete) begin
            tmo_d = '0;
            if (wait_q) begin
                state_d = S_WAIT_R;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            opcode_q    <= 8'h00;
            payload_q   <= '0;
            pay_len_q   <= '0;
            rsp_len_q   <= '0;
            wait_q      <= 1'b0;
            pay_idx_q   <= '0;
            rsp_cnt_q   <= '0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_last_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            opcode_q    <= opcode_d;
            payload_q   <= payload_d;
            pay_len_q   <= pay_len_d;
            rsp_len_q   <= rsp_len_d;
            wait_q      <= wait_d;
            pay_idx_q   <= pay_idx_d;
            rsp_cnt_q   <= rsp_cnt_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_last  = rsp_last_q;
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;

    // The opcode is only needed at load time; kept for debug visibility.
    logic w_unused;
    assign w_unused = ^opcode_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_host_sequencer
// Brief   : Directed self-checking bench with a uart_tx responder model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_host_sequencer;

    localparam int PB     = 4;
    localparam int MR     = 32;
    localparam int TMO    = 1000;
    localparam int LEN_W  = $clog2(PB + 1);
    localparam int RSP_W  = $clog2(MR + 1);
    localparam int TX_LAT = 3;

    logic              clk;
    logic              i_rst;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [7:0]        i_cmd_opcode;
    logic [8*PB-1:0]   i_cmd_payload;
    logic [LEN_W-1:0]  i_cmd_pay_len;
    logic [RSP_W-1:0]  i_cmd_rsp_len;
    logic              i_cmd_wait_rdy;
    logic              o_tx_start;
    logic [7:0]        o_tx_data;
    logic              i_tx_done;
    logic              i_rx_valid;
    logic [7:0]        i_rx_data;
    logic              o_rsp_valid;
    logic [7:0]        o_rsp_data;
    logic              o_rsp_last;
    logic              o_done;
    logic              o_timeout;
    logic              o_busy;

    logic       rx_valid_main, rx_valid_mdl;
    logic [7:0] rx_data_main, rx_data_mdl;
    logic       coincide_arm;
    logic [7:0] coincide_data;

    assign i_rx_valid = rx_valid_main | rx_valid_mdl;
    assign i_rx_data  = rx_valid_mdl ? rx_data_mdl : rx_data_main;

    uart_host_sequencer #(
        .PAYLOAD_BYTES (PB),
        .MAX_RSP_BYTES (MR),
        .TIMEOUT_CYCLES(TMO),
        .READY_CHAR    (8'h52)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_opcode  (i_cmd_opcode),
        .i_cmd_payload (i_cmd_payload),
        .i_cmd_pay_len (i_cmd_pay_len),
        .i_cmd_rsp_len (i_cmd_rsp_len),
        .i_cmd_wait_rdy(i_cmd_wait_rdy),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .i_tx_done     (i_tx_done),
        .i_rx_valid    (i_rx_valid),
        .i_rx_data     (i_rx_data),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_last    (o_rsp_last),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // uart_tx stand-in: logs each byte and answers with tx_done after TX_LAT cycles
    logic [7:0] tx_log[$];
    int         tx_start_cyc[$];
    int         tx_done_cyc[$];
    initial begin
        bit in_flight;
        int cnt;
        in_flight    = 1'b0;
        cnt          = 0;
        i_tx_done    = 1'b0;
        rx_valid_mdl = 1'b0;
        rx_data_mdl  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            i_tx_done    = 1'b0;
            rx_valid_mdl = 1'b0;
            if (i_rst) begin
                in_flight = 1'b0;
            end else if (!in_flight) begin
                if (o_tx_start) begin
                    in_flight = 1'b1;
                    cnt       = TX_LAT;
                    tx_log.push_back(o_tx_data);
                    tx_start_cyc.push_back(cyc);
                end
            end else if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    i_tx_done = 1'b1;
                    tx_done_cyc.push_back(cyc);
                    if (coincide_arm) begin
                        rx_valid_mdl = 1'b1;
                        rx_data_mdl  = coincide_data;
                    end
                end
            end else if (!o_tx_start) begin
                in_flight = 1'b0;
            end
        end
    end

    logic [7:0] rsp_log[$];
    int         done_cnt = 0, tmo_cnt = 0, last_cnt = 0;
    int         done_cyc = 0, tmo_cyc = 0, rsp_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       ready_at_done = 1'b0;
    always @(negedge clk) begin
        if (o_rsp_valid) begin
            rsp_log.push_back(o_rsp_data);
            rsp_cyc = cyc;
            if (o_rsp_last) begin
                last_cnt  = last_cnt + 1;
                last_data = o_rsp_data;
            end
        end
        if (o_done) begin
            done_cnt      = done_cnt + 1;
            done_cyc      = cyc;
            ready_at_done = o_cmd_ready;
        end
        if (o_timeout) begin
            tmo_cnt = tmo_cnt + 1;
            tmo_cyc = cyc;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int tb0, rb0, db0, tmb0, lb0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        tb0  = tx_log.size();
        rb0  = rsp_log.size();
        db0  = done_cnt;
        tmb0 = tmo_cnt;
        lb0  = last_cnt;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] pay,
                            input int pl, input int rl, input logic w);
        for (int i = 0; i < 50 && !o_cmd_ready; i++) tick();
        check("cmd_ready_before_cmd", 32'(o_cmd_ready), 32'd1);
        i_cmd_valid    = 1'b1;
        i_cmd_opcode   = op;
        i_cmd_payload  = pay;
        i_cmd_pay_len  = LEN_W'(pl);
        i_cmd_rsp_len  = RSP_W'(rl);
        i_cmd_wait_rdy = w;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_valid_main = 1'b1;
        rx_data_main  = d;
        tick();
        rx_valid_main = 1'b0;
        tick();
    endtask

    task automatic wait_end(input int max, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if ((done_cnt + tmo_cnt) > (db0 + tmb0)) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        i_rst          = 1'b1;
        i_cmd_valid    = 1'b0;
        i_cmd_opcode   = 8'h00;
        i_cmd_payload  = '0;
        i_cmd_pay_len  = '0;
        i_cmd_rsp_len  = '0;
        i_cmd_wait_rdy = 1'b0;
        rx_valid_main  = 1'b0;
        rx_data_main   = 8'h00;
        coincide_arm   = 1'b0;
        coincide_data  = 8'h00;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_outputs", {27'd0, o_rsp_valid, o_rsp_last, o_done, o_timeout, 1'b0}, 32'd0);
        i_rst = 1'b0;
        tick();

        // Opcode only, no response
        snap();
        send_cmd(8'h08, 32'h0, 0, 0, 1'b0);
        wait_end(100, "t1_end");
        check("t1_tx_count", 32'(tx_log.size() - tb0), 32'd1);
        check("t1_tx_byte", 32'(tx_log[tb0]), 32'h08);
        check("t1_done", 32'(done_cnt - db0), 32'd1);
        check("t1_ready_at_done", 32'(ready_at_done), 32'd1);
        check("t1_tx_start_idle", 32'(o_tx_start), 32'd0);

        // Opcode + 4 payload bytes
        snap();
        send_cmd(8'h07, 32'h3C010001, 4, 0, 1'b0);
        wait_end(200, "t2_end");
        check("t2_tx_count", 32'(tx_log.size() - tb0), 32'd5);
        check("t2_b0", 32'(tx_log[tb0]), 32'h07);
        check("t2_b1", 32'(tx_log[tb0+1]), 32'h01);
        check("t2_b2", 32'(tx_log[tb0+2]), 32'h00);
        check("t2_b3", 32'(tx_log[tb0+3]), 32'h01);
        check("t2_b4", 32'(tx_log[tb0+4]), 32'h3C);
        for (int i = 0; i < 4; i++)
            check("t2_start_gap", 32'(tx_start_cyc[tb0+i+1] - tx_done_cyc[tb0+i]), 32'd2);
        check("t2_done_latency", 32'(done_cyc - tx_done_cyc[tb0+4]), 32'd1);
        check("t2_done", 32'(done_cnt - db0), 32'd1);

        // Oversized pay_len clamps to 4
        snap();
        send_cmd(8'h09, 32'h44332211, 7, 0, 1'b0);
        wait_end(200, "clamp_end");
        check("clamp_tx_count", 32'(tx_log.size() - tb0), 32'd5);
        check("clamp_b4", 32'(tx_log[tb0+4]), 32'h44);
        check("clamp_b1", 32'(tx_log[tb0+1]), 32'h11);

        // 4 response bytes then ready char
        snap();
        send_cmd(8'h02, 32'h0, 0, 4, 1'b1);
        repeat (10) tick();
        check("t3_busy", 32'(o_busy), 32'd1);
        check("t3_not_ready", 32'(o_cmd_ready), 32'd0);
        rx_byte(8'hAA);
        rx_byte(8'hBB);
        rx_byte(8'hCC);
        rx_byte(8'hDD);
        tick();
        check("t3_rsp_count", 32'(rsp_log.size() - rb0), 32'd4);
        check("t3_rsp0", 32'(rsp_log[rb0]), 32'hAA);
        check("t3_rsp3", 32'(rsp_log[rb0+3]), 32'hDD);
        check("t3_last_count", 32'(last_cnt - lb0), 32'd1);
        check("t3_last_data", 32'(last_data), 32'hDD);
        check("t3_no_early_done", 32'(done_cnt - db0), 32'd0);
        rx_byte(8'h52);
        wait_end(50, "t3_end");
        check("t3_done", 32'(done_cnt - db0), 32'd1);

        // Stray byte in WAIT_R is dropped
        snap();
        send_cmd(8'h02, 32'h0, 0, 0, 1'b1);
        repeat (10) tick();
        rx_byte(8'h78);
        repeat (3) tick();
        check("t4_no_done_on_x", 32'(done_cnt - db0), 32'd0);
        check("t4_still_busy", 32'(o_busy), 32'd1);
        rx_byte(8'h52);
        wait_end(50, "t4_end");
        check("t4_done", 32'(done_cnt - db0), 32'd1);
        check("t4_no_rsp", 32'(rsp_log.size() - rb0), 32'd0);

        // READY_CHAR inside RECV is ordinary data
        snap();
        send_cmd(8'h04, 32'h0, 0, 2, 1'b0);
        repeat (10) tick();
        rx_byte(8'h52);
        rx_byte(8'h11);
        wait_end(50, "rdata_end");
        check("rdata_rsp0", 32'(rsp_log[rb0]), 32'h52);
        check("rdata_last", 32'(last_data), 32'h11);
        check("rdata_done", 32'(done_cnt - db0), 32'd1);

        // Rx byte coincident with final tx_done becomes response byte 1
        snap();
        coincide_data = 8'h5A;
        coincide_arm  = 1'b1;
        send_cmd(8'h05, 32'h0, 0, 1, 1'b0);
        wait_end(100, "coin_end");
        coincide_arm = 1'b0;
        check("coin_rsp_count", 32'(rsp_log.size() - rb0), 32'd1);
        check("coin_rsp0", 32'(rsp_log[rb0]), 32'h5A);
        check("coin_last", 32'(last_cnt - lb0), 32'd1);
        check("coin_done", 32'(done_cnt - db0), 32'd1);

        // Timeout after 10 of 17 bytes
        snap();
        send_cmd(8'h03, 32'h0, 0, 17, 1'b0);
        repeat (10) tick();
        for (int i = 0; i < 10; i++) rx_byte(8'h30 + 8'(i));
        wait_end(1200, "t5_end");
        check("t5_rsp_count", 32'(rsp_log.size() - rb0), 32'd10);
        check("t5_rsp9", 32'(rsp_log[rb0+9]), 32'h39);
        check("t5_no_last", 32'(last_cnt - lb0), 32'd0);
        check("t5_timeout", 32'(tmo_cnt - tmb0), 32'd1);
        check("t5_no_done", 32'(done_cnt - db0), 32'd0);
        check("t5_timeout_delay", 32'(tmo_cyc - rsp_cyc), 32'd1000);

        // Reset during the third payload byte
        snap();
        send_cmd(8'h07, 32'hDDCCBBAA, 4, 0, 1'b0);
        for (int i = 0; i < 100 && (tx_log.size() - tb0) < 4; i++) tick();
        check("t6_reached_pay2", 32'(tx_log.size() - tb0), 32'd4);
        check("t6_pay2_byte", 32'(tx_log[tb0+3]), 32'hCC);
        i_rst = 1'b1;
        #1;
        check("t6_tx_start_async", 32'(o_tx_start), 32'd0);
        check("t6_ready_async", 32'(o_cmd_ready), 32'd1);
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (3) tick();
        check("t6_no_done", 32'(done_cnt - db0), 32'd0);
        check("t6_no_timeout", 32'(tmo_cnt - tmb0), 32'd0);

        snap();
        send_cmd(8'h08, 32'h0, 0, 0, 1'b0);
        wait_end(100, "t7_end");
        check("t7_tx_count", 32'(tx_log.size() - tb0), 32'd1);
        check("t7_tx_byte", 32'(tx_log[tb0]), 32'h08);
        check("t7_done", 32'(done_cnt - db0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
